cpu_mem: RTL and testbench

- Memory-access stage of the PLP 5-stage pipeline, directly downstream of execute.
- Consumes the EX pipeline register (control, ALU result, store data, write address, link address) and performs the data-bus load or store with a request/ack handshake.
- Stalls the pipeline until the access completes, then registers the results for the writeback stage.
- Forwards writeback data into the store-data path.

---
 rtl/cpu_mem.sv | 116 +++++++++++
 tb/tb_cpu_mem.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem.sv
// Memory-access stage: issues the data-bus load/store and stalls until it completes.
// The stage then registers the EX fields and the load data for writeback.
module cpu_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  input  logic        int_flush,
  input  logic        ex_c_rfw,
  input  logic [1:0]  ex_c_wbsource,
  input  logic [1:0]  ex_c_drw,
  input  logic [31:0] ex_alu_r,
  input  logic [31:0] ex_rfb,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_jalra,
  input  logic [4:0]  ex_rt,
  input  logic [31:0] wb_wdata,
  input  logic        wb_rfw,
  input  logic [4:0]  wb_waddr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        p_c_rfw,
  output logic [1:0]  p_c_wbsource,
  output logic [31:0] p_alu_r,
  output logic [31:0] p_mem_data,
  output logic [4:0]  p_rf_waddr,
  output logic [31:0] p_jalra
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        access, is_rd, is_wr, req;
  logic [31:0] fwd, wdata_q, rdata_q;

  assign access    = (ex_c_drw != 2'b00);
  assign is_rd     = ex_c_drw[1];
  assign is_wr     = (ex_c_drw == 2'b01);
  assign fwd       = (wb_rfw && wb_waddr == ex_rt && wb_waddr != 5'd0) ? wb_wdata : ex_rfb;
  assign mem_addr  = {ex_alu_r[31:2], 2'b00};
  assign mem_stall = access && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (access && mem_ack) state_nxt = DONE;
        else if (access)       state_nxt = BUSY;
      end
      BUSY:    if (mem_ack)    state_nxt = DONE;
      DONE:    if (!cpu_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are masked by rst so they drop in the very cycle reset is sampled.
  always_comb begin
    req       = 1'b0;
    mem_wdata = wdata_q;
    case (state)
      IDLE: begin
        req       = access;
        mem_wdata = fwd;
      end
      BUSY:    req = access;
      default: req = 1'b0;
    endcase
    mem_rd = req && is_rd && !rst;
    mem_wr = req && is_wr && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      p_c_rfw      <= 1'b0;
      p_c_wbsource <= 2'b00;
      p_alu_r      <= 32'h0;
      p_mem_data   <= 32'h0;
      p_rf_waddr   <= 5'd0;
      p_jalra      <= 32'h0;
    end else begin
      if (state == IDLE && access)
        wdata_q <= fwd;
      if (((state == IDLE && access) || state == BUSY) && mem_ack)
        rdata_q <= mem_rdata;
      if (!cpu_stall) begin
        if (int_flush) begin
          p_c_rfw      <= 1'b0;
          p_c_wbsource <= 2'b00;
          p_alu_r      <= 32'h0;
          p_mem_data   <= 32'h0;
          p_rf_waddr   <= 5'd0;
          p_jalra      <= 32'h0;
        end else begin
          p_c_rfw      <= ex_c_rfw;
          p_c_wbsource <= ex_c_wbsource;
          p_alu_r      <= ex_alu_r;
          p_mem_data   <= is_rd ? rdata_q : 32'h0;
          p_rf_waddr   <= ex_rf_waddr;
          p_jalra      <= ex_jalra;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem.sv
// Bench for cpu_mem: per-cycle bus checks plus a scoreboard of expected WB register contents.
module tb_cpu_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_stall, ext_stall, int_flush;
  logic        ex_c_rfw;
  logic [1:0]  ex_c_wbsource, ex_c_drw;
  logic [31:0] ex_alu_r, ex_rfb, ex_jalra;
  logic [4:0]  ex_rf_waddr, ex_rt;
  logic [31:0] wb_wdata;
  logic        wb_rfw;
  logic [4:0]  wb_waddr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack, mem_stall;
  logic        p_c_rfw;
  logic [1:0]  p_c_wbsource;
  logic [31:0] p_alu_r, p_mem_data, p_jalra;
  logic [4:0]  p_rf_waddr;

  typedef struct packed {
    logic        rfw;
    logic [1:0]  wbs;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  wa;
    logic [31:0] jal;
  } pr_t;

  pr_t exp_q[$];
  pr_t mon_e;
  logic mon_en = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  assign cpu_stall = mem_stall | ext_stall;

  always #5 clk = ~clk;

  cpu_mem dut (
    .clk(clk), .rst(rst), .cpu_stall(cpu_stall), .int_flush(int_flush),
    .ex_c_rfw(ex_c_rfw), .ex_c_wbsource(ex_c_wbsource), .ex_c_drw(ex_c_drw),
    .ex_alu_r(ex_alu_r), .ex_rfb(ex_rfb), .ex_rf_waddr(ex_rf_waddr),
    .ex_jalra(ex_jalra), .ex_rt(ex_rt),
    .wb_wdata(wb_wdata), .wb_rfw(wb_rfw), .wb_waddr(wb_waddr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource), .p_alu_r(p_alu_r),
    .p_mem_data(p_mem_data), .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_p_zero(input string tag);
    check({tag, "_p_ctrl"}, {24'h0, p_c_rfw, p_c_wbsource, p_rf_waddr}, 32'h0);
    check({tag, "_p_alu"},  p_alu_r,    32'h0);
    check({tag, "_p_md"},   p_mem_data, 32'h0);
    check({tag, "_p_jal"},  p_jalra,    32'h0);
  endtask

  // Every pipeline advance must match the oldest expected WB entry.
  always @(posedge clk) begin
    if (mon_en && !rst && !cpu_stall) begin
      #1;
      if (exp_q.size() == 0) begin
        check("adv_unexpected", 32'h1, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("p_ctrl", {24'h0, p_c_rfw, p_c_wbsource, p_rf_waddr},
              {24'h0, mon_e.rfw, mon_e.wbs, mon_e.wa});
        check("p_alu_r",    p_alu_r,    mon_e.alu);
        check("p_mem_data", p_mem_data, mon_e.md);
        check("p_jalra",    p_jalra,    mon_e.jal);
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the advance.
  // ack_dly = cycle index of the bus ack (-1: none); xstall = external stall cycles after completion.
  task automatic issue(input logic [1:0] drw, input logic rfw, input logic [1:0] wbs,
                       input logic [31:0] alu, input logic [31:0] rfb, input logic [4:0] wa,
                       input logic [31:0] jal, input logic [4:0] rt,
                       input logic wrfw, input logic [4:0] wwa, input logic [31:0] wwd,
                       input int ack_dly, input int xstall, input logic flush,
                       input logic [31:0] rdata);
    pr_t         e;
    logic [31:0] fwd0;
    logic        acc, rd, wr, adv;
    int          n;
    acc  = (drw != 2'b00);
    rd   = drw[1];
    wr   = (drw == 2'b01);
    fwd0 = (wrfw && wwa == rt && wwa != 5'd0) ? wwd : rfb;
    e    = flush ? '0 : {rfw, wbs, alu, (rd ? rdata : 32'h0), wa, jal};
    exp_q.push_back(e);
    ex_c_drw = drw; ex_c_rfw = rfw; ex_c_wbsource = wbs; ex_alu_r = alu;
    ex_rfb = rfb; ex_rf_waddr = wa; ex_jalra = jal; ex_rt = rt;
    wb_rfw = wrfw; wb_waddr = wwa; wb_wdata = wwd;
    int_flush = flush;
    mon_en = 1'b1;
    adv = 1'b0;
    n = 0;
    while (!adv && n < 40) begin
      ext_stall = (n > ack_dly) && (n <= ack_dly + xstall);
      // Acks during the external-stall window arrive with no request pending.
      mem_ack   = (acc && n == ack_dly) || ext_stall;
      mem_rdata = (n == ack_dly) ? rdata : $urandom;
      if (n > 0) wb_wdata = $urandom;
      #2;
      check("mem_stall", {31'h0, mem_stall}, {31'h0, acc && n <= ack_dly});
      check("mem_rd",    {31'h0, mem_rd},    {31'h0, rd && n <= ack_dly});
      check("mem_wr",    {31'h0, mem_wr},    {31'h0, wr && n <= ack_dly});
      if (wr && n <= ack_dly) check("mem_wdata", mem_wdata, fwd0);
      if (acc && n == 0)      check("mem_addr",  mem_addr, {alu[31:2], 2'b00});
      adv = !cpu_stall;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!adv) check("advance_timeout", 32'h0, 32'h1);
    mon_en = 1'b0; ext_stall = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; int_flush = 1'b0;
    ex_c_rfw = 1'b0; ex_c_wbsource = 2'b00; ex_c_drw = 2'b00;
    ex_alu_r = 32'h0; ex_rfb = 32'h0; ex_rf_waddr = 5'd0; ex_jalra = 32'h0; ex_rt = 5'd0;
    wb_wdata = 32'h0; wb_rfw = 1'b0; wb_waddr = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    check_p_zero("reset");
    check("reset_rd",    {31'h0, mem_rd},    32'h0);
    check("reset_wr",    {31'h0, mem_wr},    32'h0);
    check("reset_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //     drw    rfw   wbs    alu           rfb           wa     jal           rt     wrfw  wwa    wwd           ack xs flush rdata
    issue(2'b00, 1'b1, 2'd0, 32'h0000_1234, 32'h0,        5'd3,  32'h0000_0040, 5'd0,  1'b0, 5'd0,  32'h0,        -1, 0, 1'b0, 32'h0);
    issue(2'b10, 1'b1, 2'd1, 32'h0000_0103, 32'h0,        5'd4,  32'h0000_0044, 5'd0,  1'b0, 5'd0,  32'h0,         0, 0, 1'b0, 32'hDEAD_BEEF);
    issue(2'b01, 1'b0, 2'd0, 32'h0000_0208, 32'h0,        5'd0,  32'h0000_0048, 5'd5,  1'b1, 5'd5,  32'h0000_A5A5, 2, 0, 1'b0, 32'h0);
    issue(2'b01, 1'b0, 2'd0, 32'h0000_020C, 32'h0000_1111, 5'd0, 32'h0000_004C, 5'd0,  1'b1, 5'd0,  32'h0000_0077, 1, 0, 1'b0, 32'h0);
    issue(2'b01, 1'b0, 2'd0, 32'h0000_0210, 32'h0000_2222, 5'd0, 32'h0000_0050, 5'd7,  1'b0, 5'd7,  32'h0000_0099, 0, 0, 1'b0, 32'h0);
    issue(2'b10, 1'b1, 2'd1, 32'h0000_0301, 32'h0,        5'd6,  32'h0000_0054, 5'd0,  1'b0, 5'd0,  32'h0,         0, 2, 1'b0, 32'h1357_9BDF);
    issue(2'b10, 1'b1, 2'd1, 32'h0000_0400, 32'h0,        5'd8,  32'h0000_0058, 5'd0,  1'b0, 5'd0,  32'h0,         2, 0, 1'b1, 32'hCAFE_F00D);
    issue(2'b00, 1'b1, 2'd2, 32'h0000_5555, 32'h0,        5'd31, 32'h0000_0060, 5'd0,  1'b0, 5'd0,  32'h0,        -1, 1, 1'b0, 32'h0);
    issue(2'b11, 1'b1, 2'd1, 32'h0000_0503, 32'h0,        5'd9,  32'h0000_0064, 5'd0,  1'b0, 5'd0,  32'h0,         1, 0, 1'b0, 32'h2468_ACE0);

    // Reset while a load waits in BUSY; the ack arriving after reset must be ignored.
    ex_c_drw = 2'b10; ex_c_rfw = 1'b1; ex_c_wbsource = 2'd1; ex_alu_r = 32'h0000_0600;
    ex_rf_waddr = 5'd10; ex_jalra = 32'h0000_0068; int_flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    #2;
    check("rstseq_rd_idle", {31'h0, mem_rd}, 32'h1);
    @(negedge clk);
    #2;
    check("rstseq_rd_busy", {31'h0, mem_rd}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstseq_rd_in_rst", {31'h0, mem_rd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ex_c_drw = 2'b00; ex_c_rfw = 1'b0; ex_c_wbsource = 2'd0; ex_alu_r = 32'h0;
    ex_rf_waddr = 5'd0; ex_jalra = 32'h0;
    mem_ack = 1'b1;
    #2;
    check_p_zero("rstseq");
    check("rstseq_rd_after", {31'h0, mem_rd},    32'h0);
    check("rstseq_stall",    {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    #2;
    check_p_zero("rstseq_late_ack");
    @(negedge clk);
    issue(2'b10, 1'b1, 2'd1, 32'h0000_0700, 32'h0, 5'd12, 32'h0000_006C, 5'd0, 1'b0, 5'd0, 32'h0, 1, 0, 1'b0, 32'h7777_8888);

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
